rv32i_mmio_slave: RTL and testbench

Memory-mapped I/O responder on the core's data port, in parallel with the synchronous dual-port RAM. It decodes the data-side address, write enable, byte enables and write data, and returns read data with the same one-cycle latency as the RAM. It contains a GPIO output register, a synchronised GPIO input with rising-edge capture, and a 32-bit timer with compare match and interrupt. The top level ORs d_rdata into the RAM read path, qualified by hit.

---
 rtl/rv32i_mmio_slave.sv | 141 ++++++++++++++
 tb/tb_rv32i_mmio_slave.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rv32i_mmio_slave.sv
// Memory-mapped I/O responder on the data port: a GPIO output register, a synchronised GPIO input
// with rising-edge capture, and a 32-bit timer with compare match and interrupt. Reads have one cycle of latency.
module rv32i_mmio_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       d_addr,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              hit,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);
    localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
    localparam logic [2:0] OFF_EDGE_CAP = 3'd2;
    localparam logic [2:0] OFF_TMR_CNT  = 3'd3;
    localparam logic [2:0] OFF_TMR_CMP  = 3'd4;
    localparam logic [2:0] OFF_TMR_CTRL = 3'd5;

    logic [GPIO_W-1:0] gpio_out_reg, gpio_out_next;
    logic [GPIO_W-1:0] sync1_reg, sync2_reg, sync3_reg;
    logic [GPIO_W-1:0] edge_cap_reg, edge_cap_next, edge_clr;
    logic [31:0]       cnt_reg, cnt_next, cmp_reg, cmp_next;
    logic              en_reg, en_next, ar_reg, ar_next;
    logic              flag_reg, flag_next, ie_reg, ie_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic              hit_reg;

    logic [31:0] lane_mask;
    logic        sel, mapped, wr, cnt_wr, ctrl_wr, match;
    logic [2:0]  offset;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{d_be[gi]}};
        end
    endgenerate

    // d_addr holds byte address bits [31:2], so window compare uses d_addr[29:6].
    assign sel     = (d_addr[29:6] == BASE_ADDR[31:8]);
    assign mapped  = sel && (d_addr[5:3] == 3'b000);
    assign offset  = d_addr[2:0];
    assign wr      = mapped && d_we;
    assign cnt_wr  = wr && (offset == OFF_TMR_CNT) && (d_be != 4'b0000);
    assign ctrl_wr = wr && (offset == OFF_TMR_CTRL) && d_be[0];
    assign match   = en_reg && (cnt_reg == cmp_reg);

    always_comb begin
        gpio_out_next = gpio_out_reg;
        edge_clr      = '0;
        cnt_next      = cnt_reg;
        cmp_next      = cmp_reg;
        en_next       = en_reg;
        ar_next       = ar_reg;
        ie_next       = ie_reg;
        rdata_next    = 32'h0;

        if (wr && offset == OFF_GPIO_OUT)
            gpio_out_next = (gpio_out_reg & ~lane_mask[GPIO_W-1:0]) |
                            (d_wdata[GPIO_W-1:0] & lane_mask[GPIO_W-1:0]);
        if (wr && offset == OFF_EDGE_CAP)
            edge_clr = d_wdata[GPIO_W-1:0] & lane_mask[GPIO_W-1:0];
        if (wr && offset == OFF_TMR_CMP)
            cmp_next = (cmp_reg & ~lane_mask) | (d_wdata & lane_mask);

        // CPU write beats the running timer; a match only counts without a write.
        if (cnt_wr)
            cnt_next = (cnt_reg & ~lane_mask) | (d_wdata & lane_mask);
        else if (match)
            cnt_next = ar_reg ? 32'h0 : cnt_reg + 32'd1;
        else if (en_reg)
            cnt_next = cnt_reg + 32'd1;

        if (ctrl_wr) begin
            en_next = d_wdata[0];
            ar_next = d_wdata[1];
            ie_next = d_wdata[3];
        end

        if (mapped) begin
            case (offset)
                OFF_GPIO_OUT: rdata_next = 32'(gpio_out_reg);
                OFF_GPIO_IN:  rdata_next = 32'(sync2_reg);
                OFF_EDGE_CAP: rdata_next = 32'(edge_cap_reg);
                OFF_TMR_CNT:  rdata_next = cnt_reg;
                OFF_TMR_CMP:  rdata_next = cmp_reg;
                OFF_TMR_CTRL: rdata_next = {28'h0, ie_reg, flag_reg, ar_reg, en_reg};
                default:      rdata_next = 32'h0;
            endcase
        end
    end

    // Set wins over a simultaneous write-one-to-clear for both sticky registers.
    assign edge_cap_next = (edge_cap_reg & ~edge_clr) | (sync2_reg & ~sync3_reg);
    assign flag_next     = (match && !cnt_wr) ||
                           (flag_reg && !(ctrl_wr && d_wdata[2]));

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out_reg <= '0;
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            sync3_reg    <= '0;
            edge_cap_reg <= '0;
            cnt_reg      <= 32'h0;
            cmp_reg      <= 32'h0;
            en_reg       <= 1'b0;
            ar_reg       <= 1'b0;
            flag_reg     <= 1'b0;
            ie_reg       <= 1'b0;
            rdata_reg    <= 32'h0;
            hit_reg      <= 1'b0;
        end else begin
            gpio_out_reg <= gpio_out_next;
            sync1_reg    <= gpio_in;
            sync2_reg    <= sync1_reg;
            sync3_reg    <= sync2_reg;
            edge_cap_reg <= edge_cap_next;
            cnt_reg      <= cnt_next;
            cmp_reg      <= cmp_next;
            en_reg       <= en_next;
            ar_reg       <= ar_next;
            flag_reg     <= flag_next;
            ie_reg       <= ie_next;
            rdata_reg    <= rdata_next;
            hit_reg      <= sel;
        end
    end

    assign d_rdata  = rdata_reg;
    assign hit      = hit_reg;
    assign gpio_out = gpio_out_reg;
    assign irq      = flag_reg & ie_reg;
endmodule

// File: tb/tb_rv32i_mmio_slave.sv
// Bench for rv32i_mmio_slave: a register-access vector table plus hand-written
// GPIO edge, timer, wrap and reset sequences, with read results checked through a scoreboard queue.
module tb_rv32i_mmio_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        hit;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;

    rv32i_mmio_slave #(.BASE_ADDR(32'h0000_8000), .GPIO_W(8)) dut (
        .clk(clk), .reset(reset), .d_addr(d_addr), .d_we(d_we), .d_be(d_be),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .hit(hit), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        hit;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic [7:0]  exp_gpio;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[16];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: expected read response is queued at drive time, popped after the edge.
    task automatic bus(input string name, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_hit);
        exp_t e;
        d_addr  = addr[31:2];
        d_we    = we;
        d_be    = be;
        d_wdata = wdata;
        sb_q.push_back('{exp_rd, exp_hit});
        @(posedge clk);
        #1;
        d_we    = 1'b0;
        d_be    = 4'h0;
        d_addr  = 30'h40;
        d_wdata = 32'h0;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check({name, ".rdata"}, d_rdata, e.rd);
            check({name, ".hit"}, {31'h0, hit}, {31'h0, e.hit});
        end
        $display("%-12s addr=%08h we=%0d be=%h wd=%08h -> rdata=%08h hit=%0d gpio_out=%02h irq=%0d",
                 name, addr, we, be, wdata, d_rdata, hit, gpio_out, irq);
    endtask

    task automatic idle();
        bus("idle", 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{32'h8000, 1'b1, 4'hF, 32'h0000_00A5, 32'h0,         1'b1, 8'hA5};
        vecs[1]  = '{32'h8000, 1'b0, 4'h0, 32'h0,         32'hA5,        1'b1, 8'hA5};
        vecs[2]  = '{32'h801C, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 8'hA5};
        vecs[3]  = '{32'h0100, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 8'hA5};
        vecs[4]  = '{32'h800C, 1'b1, 4'h5, 32'h1122_3344, 32'h0,         1'b1, 8'hA5};
        vecs[5]  = '{32'h800C, 1'b0, 4'h0, 32'h0,         32'h0022_0044, 1'b1, 8'hA5};
        vecs[6]  = '{32'h8000, 1'b1, 4'h0, 32'hFF,        32'hA5,        1'b1, 8'hA5};
        vecs[7]  = '{32'h8000, 1'b1, 4'h2, 32'h1234_5678, 32'hA5,        1'b1, 8'hA5};
        vecs[8]  = '{32'h8020, 1'b1, 4'hF, 32'h0,         32'h0,         1'b1, 8'hA5};
        vecs[9]  = '{32'h8000, 1'b0, 4'h0, 32'h0,         32'hA5,        1'b1, 8'hA5};
        vecs[10] = '{32'h8010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b1, 8'hA5};
        vecs[11] = '{32'h8010, 1'b0, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b1, 8'hA5};
        vecs[12] = '{32'h8004, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 8'hA5};
        vecs[13] = '{32'h8000, 1'b1, 4'h1, 32'h3C,        32'hA5,        1'b1, 8'h3C};
        vecs[14] = '{32'h8000, 1'b0, 4'h0, 32'h0,         32'h3C,        1'b1, 8'h3C};
        vecs[15] = '{32'h7F00, 1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 8'h3C};

        reset = 1'b1; d_addr = 30'h40; d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0; gpio_in = 8'h0;
        bus("reset", 32'h8000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        check("reset.gpio_out", {24'h0, gpio_out}, 32'h0);
        check("reset.irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            bus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata,
                vecs[i].exp_rd, vecs[i].exp_hit);
            check($sformatf("vec%0d.gpio_out", i), {24'h0, gpio_out}, {24'h0, vecs[i].exp_gpio});
        end

        // Input synchroniser latency and sticky edge capture.
        gpio_in = 8'h01;
        idle();
        bus("gpin_early", 32'h8004, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        bus("gpin_sync",  32'h8004, 1'b0, 4'h0, 32'h0, 32'h1, 1'b1);
        bus("edge_set",   32'h8008, 1'b0, 4'h0, 32'h0, 32'h1, 1'b1);
        bus("edge_w1c",   32'h8008, 1'b1, 4'h1, 32'h1, 32'h1, 1'b1);
        bus("edge_clr",   32'h8008, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        gpio_in = 8'h00;
        idle(); idle(); idle();
        gpio_in = 8'h01;
        idle();
        bus("edge_pre",   32'h8008, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        bus("edge_race",  32'h8008, 1'b1, 4'h1, 32'h1, 32'h0, 1'b1);
        bus("edge_win",   32'h8008, 1'b0, 4'h0, 32'h0, 32'h1, 1'b1);

        // Timer with autoreload and interrupt enable.
        bus("cmp5",  32'h8010, 1'b1, 4'hF, 32'h5, 32'hDEAD_BEEF, 1'b1);
        bus("cnt0",  32'h800C, 1'b1, 4'hF, 32'h0, 32'h0022_0044, 1'b1);
        bus("ctrlB", 32'h8014, 1'b1, 4'hF, 32'hB, 32'h0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            bus($sformatf("tmr%0d", k), 32'h800C, 1'b0, 4'h0, 32'h0,
                (k < 6) ? 32'(k) : 32'h0, 1'b1);
            check($sformatf("tmr%0d.irq", k), {31'h0, irq}, (k >= 5) ? 32'h1 : 32'h0);
        end
        bus("flag_w1c", 32'h8014, 1'b1, 4'h1, 32'hF, 32'hF, 1'b1);
        check("flag_w1c.irq", {31'h0, irq}, 32'h0);

        // Wrap past FFFF_FFFF without flag; match on 3 with autoreload off.
        bus("ctrl_off", 32'h8014, 1'b1, 4'h1, 32'h0, 32'hB, 1'b1);
        bus("cmp3",     32'h8010, 1'b1, 4'hF, 32'h3, 32'h5, 1'b1);
        bus("cnt_fe",   32'h800C, 1'b1, 4'hF, 32'hFFFF_FFFE, 32'h3, 1'b1);
        bus("ctrl1",    32'h8014, 1'b1, 4'h1, 32'h1, 32'h0, 1'b1);
        for (int j = 0; j < 9; j++) begin
            if (j % 2 == 0)
                bus($sformatf("wrap%0d.cnt", j), 32'h800C, 1'b0, 4'h0, 32'h0,
                    32'hFFFF_FFFE + 32'(j), 1'b1);
            else
                bus($sformatf("wrap%0d.ctrl", j), 32'h8014, 1'b0, 4'h0, 32'h0,
                    (j >= 6) ? 32'h5 : 32'h1, 1'b1);
            check($sformatf("wrap%0d.irq", j), {31'h0, irq}, 32'h0);
        end

        // Reset while the timer runs, irq is high and gpio_out is all ones.
        bus("ctrl9",  32'h8014, 1'b1, 4'h1, 32'h9, 32'h5, 1'b1);
        check("ctrl9.irq", {31'h0, irq}, 32'h1);
        bus("gpio_ff", 32'h8000, 1'b1, 4'h1, 32'hFF, 32'h3C, 1'b1);
        check("gpio_ff.gpio_out", {24'h0, gpio_out}, 32'hFF);
        reset = 1'b1;
        bus("rst_wr", 32'h8000, 1'b1, 4'hF, 32'h11, 32'h0, 1'b0);
        check("rst_wr.gpio_out", {24'h0, gpio_out}, 32'h0);
        check("rst_wr.irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        bus("rst_cnt",  32'h800C, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        bus("rst_ctrl", 32'h8014, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        bus("rst_cnt2", 32'h800C, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        bus("rst_gpio", 32'h8000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
